mac_pipe: RTL and testbench

- Pipelined, parametrised signed fixed-point multiply-accumulate unit. Successor to the combinational Q1.7 x Q1.7 -> Q1.15 multiplier.
- Accumulates a stream of a*b products onto a per-group bias and emits one saturated Q1.(OWIDTH-1) result per group.
- Uses valid/ready handshakes on both sides. Sits between the operand fetch logic and the activation/result buffer of the NN datapath.

---
 rtl/mac_pkg.sv | 34 +++
 rtl/mac_sat.sv | 22 ++
 rtl/mac_pipe.sv | 146 ++++++++++++++
 tb/tb_mac_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants, S1 payload layout and the saturation helper for the
// pipelined signed fixed-point multiply-accumulate unit.
package mac_pkg;

  localparam int MAC_IWIDTH = 8;
  localparam int MAC_OWIDTH = 16;
  localparam int MAC_ACCW   = 24;
  localparam int PROD_W     = 2 * MAC_IWIDTH;
  localparam int FRAC_ACC   = 2 * MAC_IWIDTH - 2;

  // Everything stage 1 hands to the accumulator stage besides its valid bit.
  typedef struct packed {
    logic signed [PROD_W-1:0]     product;
    logic signed [MAC_IWIDTH-1:0] bias;
    logic                         first;
    logic                         last;
  } s1_payload_t;

  // Clamp a signed value to the representable range of a width-bit signed number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int unsigned       width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/mac_sat.sv
// Combinational signed saturation from IN_W to OUT_W bits, with a flag that
// is set whenever the value had to be clipped.
module mac_sat
  import mac_pkg::*;
#(
  parameter int IN_W  = 25,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  value,
  output logic signed [OUT_W-1:0] result,
  output logic                    sat
);

  logic signed [63:0] wide;
  logic signed [63:0] clipped;

  assign wide    = 64'(value);
  assign clipped = saturate(wide, OUT_W);
  assign result  = clipped[OUT_W-1:0];
  assign sat     = (clipped != wide);

endmodule

// File: rtl/mac_pipe.sv
// Three-stage signed MAC: S1 registers a*b, S2 accumulates onto the group bias,
// S3 holds the saturated Q1.(OWIDTH-1) group result until it is taken.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int IWIDTH = MAC_IWIDTH,
  parameter int OWIDTH = MAC_OWIDTH,
  parameter int ACCW   = MAC_ACCW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] a,
  input  logic [IWIDTH-1:0] b,
  input  logic [IWIDTH-1:0] bias,
  input  logic              first,
  input  logic              last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OWIDTH-1:0] out_data,
  output logic              out_sat
);

  // Handshake: a beat moves on in_valid && in_ready, a result on
  // out_valid && out_ready; a result that is not taken freezes every stage.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // ---------------- S1: product register ----------------
  logic signed [2*IWIDTH-1:0] prod_in;
  logic                       s1_valid;
  s1_payload_t                s1;

  assign prod_in = $signed(a) * $signed(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1.product <= prod_in;
        s1.bias    <= bias;
        s1.first   <= first;
        s1.last    <= last;
      end
    end
  end

  // ---------------- S2: accumulator ----------------
  logic signed [2*IWIDTH-1:0] s1_prod;
  logic signed [IWIDTH-1:0]   s1_bias;
  logic signed [ACCW-1:0]     acc;
  logic signed [ACCW-1:0]     acc_next;
  logic signed [ACCW-1:0]     bias_ext;
  logic signed [ACCW-1:0]     base;
  logic signed [ACCW:0]       sum_wide;
  logic                       sticky;
  logic                       base_sticky;
  logic                       acc_sat;
  logic                       s2_fin;

  assign s1_prod = s1.product;
  assign s1_bias = s1.bias;

  // Bias is Q1.(IWIDTH-1); align it to the accumulator's FRAC_ACC fraction bits.
  assign bias_ext = {{(ACCW-IWIDTH){s1_bias[IWIDTH-1]}}, s1_bias} <<< (FRAC_ACC - (IWIDTH - 1));

  // acc still holds the finished sum while S3 samples it, so a beat that
  // directly follows a completed group must start from zero instead.
  always_comb begin
    base        = acc;
    base_sticky = sticky;
    if (s1.first) begin
      base        = bias_ext;
      base_sticky = 1'b0;
    end else if (s2_fin) begin
      base        = '0;
      base_sticky = 1'b0;
    end
  end

  assign sum_wide = {base[ACCW-1], base}
                  + {{(ACCW+1-2*IWIDTH){s1_prod[2*IWIDTH-1]}}, s1_prod};

  mac_sat #(
    .IN_W (ACCW + 1),
    .OUT_W(ACCW)
  ) u_acc_sat (
    .value (sum_wide),
    .result(acc_next),
    .sat   (acc_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sticky <= 1'b0;
      s2_fin <= 1'b0;
    end else if (!stall) begin
      s2_fin <= s1_valid && s1.last;
      if (s1_valid) begin
        acc    <= acc_next;
        sticky <= base_sticky | acc_sat;
      end else if (s2_fin) begin
        acc    <= '0;
        sticky <= 1'b0;
      end
    end
  end

  // ---------------- S3: output register ----------------
  logic signed [ACCW:0]     acc_shl;
  logic signed [OWIDTH-1:0] out_next;
  logic                     out_clip;

  // One extra left shift turns Q.(FRAC_ACC) into the Q1.(OWIDTH-1) output format.
  assign acc_shl = {acc, 1'b0};

  mac_sat #(
    .IN_W (ACCW + 1),
    .OUT_W(OWIDTH)
  ) u_out_sat (
    .value (acc_shl),
    .result(out_next),
    .sat   (out_clip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_fin;
      if (s2_fin) begin
        out_data <= out_next;
        out_sat  <= sticky | out_clip;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// Self-checking bench for mac_pipe: directed scenarios plus a randomized
// stream, all results compared against a group-level arithmetic model.
module tb_mac_pipe;

  localparam int IW = 8;
  localparam int OW = 16;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] a;
  logic [IW-1:0] b;
  logic [IW-1:0] bias;
  logic          first;
  logic          last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_sat;

  always #5 clk = ~clk;

  mac_pipe #(
    .IWIDTH(IW),
    .OWIDTH(OW),
    .ACCW  (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bias     (bias),
    .first    (first),
    .last     (last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  int checks = 0;
  int errors = 0;

  // expected results, {out_sat, out_data}
  logic [OW:0] exp_q[$];

  // group-level reference state: real-valued sum in units of 2^-14
  longint m_acc    = 0;
  bit     m_sticky = 1'b0;
  bit     rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input logic [IW-1:0] ia, input logic [IW-1:0] ib,
                            input logic [IW-1:0] ibias, input bit f, input bit l);
    longint acc_hi;
    longint acc_lo;
    longint v;
    bit     s;
    acc_hi = (longint'(1) << (AW - 1)) - 1;
    acc_lo = -(longint'(1) << (AW - 1));
    if (f) begin
      m_acc    = longint'($signed(ibias)) * 128;
      m_sticky = 1'b0;
    end
    m_acc = m_acc + longint'($signed(ia)) * longint'($signed(ib));
    if (m_acc > acc_hi) begin
      m_acc = acc_hi; m_sticky = 1'b1;
    end else if (m_acc < acc_lo) begin
      m_acc = acc_lo; m_sticky = 1'b1;
    end
    if (l) begin
      v = m_acc * 2;
      s = m_sticky;
      if (v > 32767) begin
        v = 32767; s = 1'b1;
      end else if (v < -32768) begin
        v = -32768; s = 1'b1;
      end
      exp_q.push_back({s, v[OW-1:0]});
      m_acc    = 0;
      m_sticky = 1'b0;
    end
  endtask

  task automatic send_beat(input logic [IW-1:0] ia, input logic [IW-1:0] ib,
                           input logic [IW-1:0] ibias, input bit f, input bit l);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      in_valid = 1'b1;
      a = ia; b = ib; bias = ibias; first = f; last = l;
      #1;
      if (in_ready) begin
        @(posedge clk);
        model_beat(ia, ib, ibias, f, l);
        done = 1'b1;
        #1 in_valid = 1'b0;
      end else begin
        waited++;
        if (waited > 200) begin
          check("in_ready_timeout", 32'(in_ready), 32'd1);
          done     = 1'b1;
          in_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_result(input string tag, input logic [OW:0] exp);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!out_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'({out_sat, out_data}), 32'(exp));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: each accepted result is matched in order; a result that
  // is held back must not change until it is taken.
  logic [OW:0] held;
  bit          was_stall = 1'b0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      was_stall = 1'b0;
    end else if (out_valid) begin
      if (was_stall) check("hold_stable", 32'({out_sat, out_data}), 32'(held));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL spurious_result: observed %0h expected none", {out_sat, out_data});
        end else begin
          check("result", 32'({out_sat, out_data}), 32'(exp_q.pop_front()));
        end
        was_stall = 1'b0;
      end else begin
        was_stall = 1'b1;
        held      = {out_sat, out_data};
      end
    end else begin
      was_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bias = '0;
    first = 1'b0; last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_sat", 32'(out_sat), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // single beat with latency profile
    send_beat(8'h40, 8'h40, 8'h00, 1'b1, 1'b1);
    @(negedge clk); #1 check("lat_after_e", 32'(out_valid), 32'd0);
    @(negedge clk); #1 check("lat_after_e1", 32'(out_valid), 32'd0);
    @(negedge clk); #1 check("lat_after_e2", 32'(out_valid), 32'd1);
    check("single_beat", 32'({out_sat, out_data}), 32'h0_2000);
    drain("drain_single");

    // two-beat group with bias
    send_beat(8'h40, 8'h40, 8'h20, 1'b1, 1'b0);
    send_beat(8'h40, 8'h40, 8'h00, 1'b0, 1'b1);
    wait_result("two_beat", 17'h0_6000);
    drain("drain_two_beat");

    // saturation, then flag cleared for the next group
    send_beat(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    wait_result("sat_pos", 17'h1_7FFF);
    send_beat(8'h80, 8'h40, 8'h00, 1'b1, 1'b1);
    wait_result("sat_cleared", 17'h0_C000);
    drain("drain_sat");

    // backpressure with three groups in flight
    out_ready = 1'b0;
    send_beat(8'h40, 8'h40, 8'h00, 1'b1, 1'b1);
    send_beat(8'h40, 8'h40, 8'h20, 1'b1, 1'b1);
    send_beat(8'h80, 8'h40, 8'h00, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_first_held", 32'({out_sat, out_data}), 32'h0_2000);
    repeat (3) @(negedge clk);
    #1;
    check("bp_still_held", 32'({out_sat, out_data}), 32'h0_2000);
    out_ready = 1'b1;
    drain("drain_backpressure");

    // back-to-back single-beat groups at full rate
    for (int i = 0; i < 8; i++) begin
      send_beat(IW'($urandom), IW'($urandom), IW'($urandom), 1'b1, 1'b1);
    end
    drain("drain_b2b");

    // reset with a pending result and a partial group
    out_ready = 1'b0;
    send_beat(8'h40, 8'h40, 8'h00, 1'b1, 1'b1);
    send_beat(8'h7F, 8'h7F, 8'h20, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset_pending", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("reset_async_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    m_acc    = 0;
    m_sticky = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1 check("post_reset_idle", 32'(out_valid), 32'd0);
    send_beat(8'h30, 8'h20, 8'h55, 1'b0, 1'b1);
    wait_result("post_reset_group", 17'h0_0C00);
    drain("drain_reset");

    // randomized stream with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send_beat(IW'($urandom), IW'($urandom), IW'($urandom),
                (i == 0) || ($urandom_range(0, 3) == 0),
                (i == 79) || ($urandom_range(0, 2) == 0));
    end
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
